// File: rtl/ppu_pkg.sv
// Definitions shared by the PPU request path: opcode encoding, default lane
// count and the state type of the lane sequencer.
package ppu_pkg;

  localparam int PPU_OP_WIDTH    = 3;
  localparam int PPU_NUM_DEFAULT = 2;

  typedef enum logic [PPU_OP_WIDTH-1:0] {
    PPU_OP_ADD = 3'd0,
    PPU_OP_SUB = 3'd1,
    PPU_OP_MUL = 3'd2,
    PPU_OP_MIN = 3'd3,
    PPU_OP_MAX = 3'd4,
    PPU_OP_AND = 3'd5,
    PPU_OP_OR  = 3'd6,
    PPU_OP_XOR = 3'd7
  } ppu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ppu_lane_sequencer.sv
// Serialises a packed multi-lane PPU request onto one pipelined lane core and
// reassembles the in-order lane results into a single packed completion.
module ppu_lane_sequencer #(
  parameter  int PPU_NUM      = ppu_pkg::PPU_NUM_DEFAULT,
  parameter  int PPU_OP_WIDTH = ppu_pkg::PPU_OP_WIDTH,
  localparam int LANE_W       = 32 / PPU_NUM
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  input  logic [31:0]             operand1_i,
  input  logic [31:0]             operand2_i,
  input  logic [PPU_OP_WIDTH-1:0] op_i,
  output logic [31:0]             result_o,
  output logic                    out_valid_o,
  output logic                    core_valid_o,
  output logic [LANE_W-1:0]       core_op1_o,
  output logic [LANE_W-1:0]       core_op2_o,
  output logic [PPU_OP_WIDTH-1:0] core_op_o,
  input  logic                    core_valid_i,
  input  logic [LANE_W-1:0]       core_result_i
);
  import ppu_pkg::*;

  localparam int             CW        = $clog2(PPU_NUM) + 1;
  localparam logic [CW-1:0]  LAST_LANE = CW'(PPU_NUM - 1);
  localparam logic [CW-1:0]  NUM_LANES = CW'(PPU_NUM);

  seq_state_e              state_q, state_d;
  logic [31:0]             op1_q, op1_d, op2_q, op2_d;
  logic [31:0]             buf_q, buf_d, result_q, result_d;
  logic [PPU_OP_WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]           iss_cnt_q, iss_cnt_d, ret_cnt_q, ret_cnt_d;
  logic                    abort_q, abort_d;
  logic                    collect, last_ret, abort_now;
  logic [LANE_W-1:0]       op1_lane [PPU_NUM];
  logic [LANE_W-1:0]       op2_lane [PPU_NUM];

  for (genvar gi = 0; gi < PPU_NUM; gi++) begin : g_lane
    assign op1_lane[gi] = op1_q[LANE_W*gi +: LANE_W];
    assign op2_lane[gi] = op2_q[LANE_W*gi +: LANE_W];
  end

  // Past the last lane the mux falls through to zero rather than aliasing lane 0.
  always_comb begin : lane_mux
    core_op1_o = '0;
    core_op2_o = '0;
    for (int k = 0; k < PPU_NUM; k++) begin
      if (iss_cnt_q == CW'(k)) begin
        core_op1_o = op1_lane[k];
        core_op2_o = op2_lane[k];
      end
    end
  end

  assign core_op_o = op_q;
  assign result_o  = result_q;

  always_comb begin : next_state
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    op_d         = op_q;
    buf_d        = buf_q;
    result_d     = result_q;
    iss_cnt_d    = iss_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    abort_d      = abort_q;
    core_valid_o = 1'b0;
    out_valid_o  = 1'b0;

    collect   = (state_q == SEQ_ISSUE || state_q == SEQ_DRAIN) && core_valid_i
                && (ret_cnt_q < NUM_LANES);
    last_ret  = collect && (ret_cnt_q == LAST_LANE);
    abort_now = abort_q || !in_valid_i;

    if (collect) begin
      for (int k = 0; k < PPU_NUM; k++) begin
        if (ret_cnt_q == CW'(k)) buf_d[LANE_W*k +: LANE_W] = core_result_i;
      end
      ret_cnt_d = ret_cnt_q + CW'(1);
    end

    unique case (state_q)
      SEQ_IDLE: begin
        if (in_valid_i) begin
          op1_d     = operand1_i;
          op2_d     = operand2_i;
          op_d      = op_i;
          iss_cnt_d = '0;
          ret_cnt_d = '0;
          abort_d   = 1'b0;
          state_d   = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        core_valid_o = 1'b1;
        iss_cnt_d    = iss_cnt_q + CW'(1);
        abort_d      = abort_now;
        if (iss_cnt_q == LAST_LANE) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: abort_d = abort_now;
      SEQ_DONE: begin
        out_valid_o = 1'b1;
        state_d     = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Final return wins over ISSUE->DRAIN, which covers a zero-latency core.
    if (last_ret) begin
      if (abort_now) begin
        state_d = SEQ_IDLE;
      end else begin
        state_d  = SEQ_DONE;
        result_d = buf_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEQ_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      op_q      <= '0;
      buf_q     <= '0;
      result_q  <= '0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      op_q      <= op_d;
      buf_q     <= buf_d;
      result_q  <= result_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      abort_q   <= abort_d;
    end
  end

endmodule

// File: tb/tb_ppu_lane_sequencer.sv
// Scoreboard bench: two sequencers (2 lanes with a latency-2 adder stub,
// 4 lanes with a combinational adder stub) driven by directed requests.
module tb_ppu_lane_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_i;
  logic        iv2, iv4;
  logic [31:0] opa, opb;
  logic [2:0]  opc;

  logic [31:0] res2, res4;
  logic        ov2, ov4, cv2, cv4, cvi2, cvi4;
  logic [15:0] c1_2, c2_2, cri2;
  logic [7:0]  c1_4, c2_4, cri4;
  logic [2:0]  cop2, cop4;

  logic        v1, v2, stray_v;
  logic [15:0] r1, r2, stray_d;

  ppu_lane_sequencer #(.PPU_NUM(2), .PPU_OP_WIDTH(3)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(iv2),
    .operand1_i(opa), .operand2_i(opb), .op_i(opc),
    .result_o(res2), .out_valid_o(ov2),
    .core_valid_o(cv2), .core_op1_o(c1_2), .core_op2_o(c2_2), .core_op_o(cop2),
    .core_valid_i(cvi2), .core_result_i(cri2)
  );

  ppu_lane_sequencer #(.PPU_NUM(4), .PPU_OP_WIDTH(3)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(iv4),
    .operand1_i(opa), .operand2_i(opb), .op_i(opc),
    .result_o(res4), .out_valid_o(ov4),
    .core_valid_o(cv4), .core_op1_o(c1_4), .core_op2_o(c2_4), .core_op_o(cop4),
    .core_valid_i(cvi4), .core_result_i(cri4)
  );

  // Latency-2 lane adder stub, sharing the sequencer reset.
  always @(posedge clk) begin
    if (rst_i) begin
      v1 <= 1'b0; v2 <= 1'b0; r1 <= '0; r2 <= '0;
    end else begin
      v1 <= cv2; r1 <= c1_2 + c2_2;
      v2 <= v1;  r2 <= r1;
    end
  end
  assign cvi2 = v2 | stray_v;
  assign cri2 = stray_v ? stray_d : r2;

  // Zero-latency lane adder stub.
  assign cvi4 = cv4;
  assign cri4 = c1_4 + c2_4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] cyc;
  } iss_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] cyc;
  } res_t;

  iss_t qi2[$], qi4[$];
  res_t qr2[$], qr4[$];
  iss_t ei2, ei4;
  res_t er2, er4;
  logic [31:0] last_res2 = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue monitors: every lane strobe must match the next expected lane.
  always @(negedge clk) begin
    if (!rst_i && cv2) begin
      if (qi2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_issue: unexpected core_valid_o at cycle %0d", cyc);
      end else begin
        ei2 = qi2.pop_front();
        chk("dut2_lane_op1", 32'(c1_2), ei2.a);
        chk("dut2_lane_op2", 32'(c2_2), ei2.b);
        chk("dut2_lane_opcode", 32'(cop2), 32'(ei2.op));
        chk("dut2_lane_cycle", 32'(cyc), ei2.cyc);
      end
    end
    if (!rst_i && cv4) begin
      if (qi4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_issue: unexpected core_valid_o at cycle %0d", cyc);
      end else begin
        ei4 = qi4.pop_front();
        chk("dut4_lane_op1", 32'(c1_4), ei4.a);
        chk("dut4_lane_op2", 32'(c2_4), ei4.b);
        chk("dut4_lane_opcode", 32'(cop4), 32'(ei4.op));
        chk("dut4_lane_cycle", 32'(cyc), ei4.cyc);
      end
    end
  end

  // Completion monitors.
  always @(negedge clk) begin
    if (!rst_i && ov2) begin
      if (qr2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_result: unexpected out_valid_o at cycle %0d, result_o %h", cyc, res2);
      end else begin
        er2 = qr2.pop_front();
        $display("txn dut2 result %h at cycle %0d", res2, cyc);
        chk("dut2_result", res2, er2.res);
        chk("dut2_result_cycle", 32'(cyc), er2.cyc);
      end
    end
    if (!rst_i && ov4) begin
      if (qr4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_result: unexpected out_valid_o at cycle %0d, result_o %h", cyc, res4);
      end else begin
        er4 = qr4.pop_front();
        $display("txn dut4 result %h at cycle %0d", res4, cyc);
        chk("dut4_result", res4, er4.res);
        chk("dut4_result_cycle", 32'(cyc), er4.cyc);
      end
    end
  end

  // Call just after a posedge; that cycle is cycle 0 of the request.
  task automatic start_req(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] exp, input bit push_res);
    int n, lw;
    logic [31:0] mask;
    iss_t e;
    res_t r;
    n    = (sel == 4) ? 4 : 2;
    lw   = 32 / n;
    mask = (32'h1 << lw) - 32'h1;
    opa = a; opb = b; opc = op;
    if (sel == 4) iv4 = 1'b1; else iv2 = 1'b1;
    for (int k = 0; k < n; k++) begin
      e.a   = (a >> (lw * k)) & mask;
      e.b   = (b >> (lw * k)) & mask;
      e.op  = op;
      e.cyc = 32'(cyc + 1 + k);
      if (sel == 4) qi4.push_back(e); else qi2.push_back(e);
    end
    if (push_res) begin
      r.res = exp;
      r.cyc = 32'(cyc + 5);
      if (sel == 4) qr4.push_back(r);
      else begin
        qr2.push_back(r);
        last_res2 = exp;
      end
    end
  endtask

  // Holds the request until the completion pulse; operands and opcode are
  // scrambled mid-request since only the accepted values may be used.
  task automatic wait_done(input int sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        opa = ~opa;
        opb = opb ^ 32'h5A5A_5A5A;
        opc = ~opc;
      end
      if ((sel == 4) ? ov4 : ov2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL dut%0d_done_timeout: out_valid_o never seen, required within 30 cycles", sel);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_i = 1'b1; iv2 = 1'b0; iv4 = 1'b0;
    opa = '0; opb = '0; opc = '0;
    stray_v = 1'b0; stray_d = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;

    chk("reset_out_valid2", 32'(ov2), 32'd0);
    chk("reset_core_valid2", 32'(cv2), 32'd0);
    chk("reset_result2", res2, 32'd0);
    chk("reset_core_op1_2", 32'(c1_2), 32'd0);
    chk("reset_core_op2_2", 32'(c2_2), 32'd0);
    chk("reset_core_op_2", 32'(cop2), 32'd0);
    chk("reset_out_valid4", 32'(ov4), 32'd0);
    chk("reset_result4", res4, 32'd0);

    // Basic request followed back-to-back by one with an upper-lane wrap.
    start_req(2, 32'h0003_0001, 32'h0004_0002, 3'd1, 32'h0007_0003, 1'b1);
    wait_done(2);
    start_req(2, 32'hFFFF_0010, 32'h0001_0020, 3'd2, 32'h0000_0030, 1'b1);
    wait_done(2);
    iv2 = 1'b0;

    // Stray lane strobe while idle.
    @(posedge clk); #1;
    stray_v = 1'b1; stray_d = 16'hAAAA;
    @(posedge clk); #1;
    stray_v = 1'b0;
    chk("stray_result_hold", res2, 32'h0000_0030);
    chk("stray_no_out_valid", 32'(ov2), 32'd0);
    chk("stray_no_issue", 32'(cv2), 32'd0);
    @(posedge clk); #1;

    // Abort at cycle 2; a new request at cycle 5 must be accepted at once.
    start_req(2, 32'h0001_0001, 32'h0001_0001, 3'd3, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_result_hold", res2, last_res2);
    start_req(2, 32'h0005_0006, 32'h0002_0003, 3'd4, 32'h0007_0009, 1'b1);
    wait_done(2);
    iv2 = 1'b0;

    // Reset while draining.
    @(posedge clk); #1;
    start_req(2, 32'h0009_0009, 32'h0001_0001, 3'd6, 32'h0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_i = 1'b1; iv2 = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    last_res2 = '0;
    chk("midrst_out_valid", 32'(ov2), 32'd0);
    chk("midrst_core_valid", 32'(cv2), 32'd0);
    chk("midrst_result", res2, 32'd0);
    chk("midrst_core_op1", 32'(c1_2), 32'd0);
    chk("midrst_core_op2", 32'(c2_2), 32'd0);
    chk("midrst_core_op", 32'(cop2), 32'd0);
    start_req(2, 32'h1234_5678, 32'h1111_1111, 3'd7, 32'h2345_6789, 1'b1);
    wait_done(2);
    iv2 = 1'b0;

    // Four lanes on a zero-latency core.
    @(posedge clk); #1;
    start_req(4, 32'h0403_0201, 32'h1010_1010, 3'd5, 32'h1413_1211, 1'b1);
    wait_done(4);
    iv4 = 1'b0;

    repeat (4) begin @(posedge clk); #1; end
    chk("final_result2_hold", res2, last_res2);
    chk("pending_dut2_issues", 32'(qi2.size()), 32'd0);
    chk("pending_dut2_results", 32'(qr2.size()), 32'd0);
    chk("pending_dut4_issues", 32'(qi4.size()), 32'd0);
    chk("pending_dut4_results", 32'(qr4.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_lane_sequencer.md
Name: ppu_lane_sequencer

Overview:
PPU-side responder for the EX-stage PPU request handshake: a level-held in_valid_i with 32-bit operands and opcode, completed by a one-cycle out_valid_o with a 32-bit result.
It serves the multi-lane (packed) operand format with a single pipelined lane core (ppu_core, instantiated outside this block), issuing lanes one per cycle and collecting results in order.
It replaces PPU_NUM parallel PPU instances when area matters; externally it is drop-in compatible with the parallel version.

Parameters:
PPU_NUM, 2, number of lanes packed in each 32-bit operand; legal values 1, 2, 4.
PPU_OP_WIDTH, 3, opcode width; must match the shared package constant.
LANE_W, 32/PPU_NUM, derived lane width; localparam, not overridable.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  EX request; held high until the cycle out_valid_o is seen
operand1_i  in  32  packed operand A; lane k = bits [LANE_W*k +: LANE_W]
operand2_i  in  32  packed operand B, same packing
op_i  in  PPU_OP_WIDTH  PPU operation
result_o  out  32  packed result, same packing
out_valid_o  out  1  one-cycle completion pulse
core_valid_o  out  1  lane issue strobe to ppu_core
core_op1_o  out  LANE_W  lane operand A
core_op2_o  out  LANE_W  lane operand B
core_op_o  out  PPU_OP_WIDTH  latched opcode
core_valid_i  in  1  lane result strobe; in order, fixed latency L >= 0
core_result_i  in  LANE_W  lane result

Behaviour:
- Reset (synchronous, rst_i=1 at posedge): state IDLE, out_valid_o=0, core_valid_o=0, result_o=0, core_op1_o/core_op2_o=0, core_op_o=0, counters=0, abort=0. ppu_core shares rst_i, so in-flight lanes are discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If in_valid_i=1: latch operand1_i, operand2_i and op_i; clear issue counter iss_cnt, return counter ret_cnt and abort; go to ISSUE.
  - core_valid_i in IDLE is ignored.
- ISSUE:
  - Each cycle: core_valid_o=1, with lane slice iss_cnt of the latched operands on core_op1_o/core_op2_o; iss_cnt++.
  - After lane PPU_NUM-1 is issued, go to DRAIN. If all results have already returned (L=0), go directly to DONE.
- Collection (ISSUE or DRAIN):
  - On core_valid_i, write core_result_i into buffer slice ret_cnt; ret_cnt++.
  - When the last lane (ret_cnt=PPU_NUM-1) returns, go to DONE, or to IDLE if abort=1.
- DONE: out_valid_o=1 for exactly one cycle, result_o loaded from the collection buffer on DONE entry; next state IDLE. in_valid_i still high during the DONE cycle belongs to the same request and is ignored.
- result_o changes only on DONE entry and holds between completions.
- Latency, measured from the first in_valid_i cycle (cycle 0): out_valid_o asserts at cycle PPU_NUM+L+1 (PPU_NUM=2, L=2 -> cycle 5; PPU_NUM=1, L=0 -> cycle 2).
- A new request may be accepted in the first cycle after DONE (back-to-back).
- Abort: if in_valid_i=0 in ISSUE or DRAIN, set abort.
  - Issue of all remaining lanes still completes, so that in-order return stays consistent.
  - On the final return, go to IDLE with no out_valid_o pulse; result_o is unchanged.
- Counters are $clog2(PPU_NUM)+1 bits wide; no wrap occurs within a request.
- PPU_NUM=1: ISSUE lasts one cycle and the operands pass through unsliced.
- Protocol violations:
  - A core_valid_i beyond PPU_NUM returns is ignored.
  - An op_i/operand change while in_valid_i is held has no effect; values latched at acceptance are used.

Decomposition:
- Shared package ppu_pkg holds: PPU_OP_WIDTH, PPU_NUM defaults, the PPU opcode enum, and the sequencer state typedef (2-bit enum).
- Single module; no sub-module is needed. The lane slice muxes are generated with a for loop. ppu_core stays external so the bench can stub it.

Test Plan:
The bench stub core computes the lane sum modulo 2^LANE_W with configurable latency L.
- PPU_NUM=2, L=2; op1=0x0003_0001, op2=0x0004_0002, in_valid_i held -> core_valid_o at cycles 1-2 with lanes 0x0001/0x0002 then 0x0003/0x0004; out_valid_o only at cycle 5; result_o=0x0007_0003.
- Back-to-back: second request 0xFFFF_0010 + 0x0001_0020 asserted the cycle after DONE -> accepted; result_o=0x0000_0030 (upper lane wraps), out_valid_o 6 cycles after the first pulse.
- Abort: in_valid_i dropped at cycle 2 of the first request -> both lanes still issued, no out_valid_o, result_o keeps its previous value, FSM reaches IDLE by cycle 5.
- Reset mid-DRAIN: rst_i=1 at cycle 3 -> next cycle all outputs 0, IDLE; a new request completes normally.
- PPU_NUM=4, L=0; op1=0x0403_0201, op2=0x1010_1010 -> one core_valid_o per cycle for 4 cycles; out_valid_o at cycle 5; result_o=0x1413_1211.
- Stray core_valid_i pulse in IDLE with core_result_i=0xAAAA -> no state change, result_o unchanged.
